// File: rtl/regfile_access_ctrl_pkg.sv
// Shared constants and types for the register-bank access controller.
// Sized for a 16 x 32-bit bank with a single write port.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // IDLE: waiting for a request; READ: bank read issued; VALID: operands presented
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bundles the decode request, operand, writeback and bank-side signals of the controller.
// slave is the controller side, master is the environment (decode, consumer, bank).
interface regfile_access_ctrl_if;
    import regfile_pkg::*;

    logic  req_valid;
    logic  req_ready;
    addr_t req_rs1;
    addr_t req_rs2;
    addr_t req_rd;
    logic  req_rd_en;

    logic  op_valid;
    logic  op_ready;
    data_t op_a;
    data_t op_b;
    addr_t op_rd;
    logic  op_rd_en;

    logic  wb_valid;
    addr_t wb_addr;
    data_t wb_data;

    addr_t rf_read_1;
    addr_t rf_read_2;
    logic  rf_signal_read;
    logic  rf_signal_write;
    addr_t rf_address_to_write;
    data_t rf_data_to_write;
    data_t rf_out_1;
    data_t rf_out_2;

    logic  pending_any;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rd_en,
        output req_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_en,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        output rf_read_1, rf_read_2, rf_signal_read,
        output rf_signal_write, rf_address_to_write, rf_data_to_write,
        input  rf_out_1, rf_out_2,
        output pending_any
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rd_en,
        input  req_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_en,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        input  rf_read_1, rf_read_2, rf_signal_read,
        input  rf_signal_write, rf_address_to_write, rf_data_to_write,
        output rf_out_1, rf_out_2,
        input  pending_any
    );

endinterface

// File: rtl/regfile_access_ctrl_scoreboard.sv
// Per-register pending bits for outstanding writebacks, with set-over-clear priority
// and combinational lookups for both sources and the destination of the incoming request.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  srst,
    input  logic  set_en,
    input  addr_t set_addr,
    input  logic  clr_en,
    input  addr_t clr_addr,
    input  addr_t rs1_addr,
    input  addr_t rs2_addr,
    input  addr_t rd_addr,
    output logic  rs1_pend,
    output logic  rs2_pend,
    output logic  rd_pend,
    output logic  pending_any
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // Decoded one-hot set/clear strobes, one slice per tracked register
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign set_vec[gi] = set_en && (set_addr == addr_t'(gi));
        assign clr_vec[gi] = clr_en && (clr_addr == addr_t'(gi));
    end

    always_comb begin
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rs1_pend    = pend_q[rs1_addr];
    assign rs2_pend    = pend_q[rs2_addr];
    assign rd_pend     = pend_q[rd_addr];
    assign pending_any = |pend_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch initiator for the register bank: issues 1-cycle-latency reads, presents
// operands on a valid/ready handshake and stalls requests that hit outstanding writebacks.
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input  logic Clock_in,
    input  logic Signal_reset,
    regfile_access_ctrl_if.slave bus
);

    state_t state_q, state_d;
    addr_t  rs1_q, rs1_d;
    addr_t  rs2_q, rs2_d;
    addr_t  rd_q, rd_d;
    logic   rd_en_q, rd_en_d;

    logic   rs1_pend;
    logic   rs2_pend;
    logic   rd_pend;
    logic   sb_pending_any;
    logic   wb_hits_src;
    logic   hazard;
    logic   req_ready;
    logic   accept;

    reg_scoreboard u_scoreboard (
        .clk         (Clock_in),
        .srst        (Signal_reset),
        .set_en      (accept & bus.req_rd_en),
        .set_addr    (bus.req_rd),
        .clr_en      (bus.wb_valid),
        .clr_addr    (bus.wb_addr),
        .rs1_addr    (bus.req_rs1),
        .rs2_addr    (bus.req_rs2),
        .rd_addr     (bus.req_rd),
        .rs1_pend    (rs1_pend),
        .rs2_pend    (rs2_pend),
        .rd_pend     (rd_pend),
        .pending_any (sb_pending_any)
    );

    // A writeback landing on a source this cycle would race the read, so it stalls too
    always_comb begin
        wb_hits_src = bus.wb_valid &&
                      ((bus.wb_addr == bus.req_rs1) || (bus.wb_addr == bus.req_rs2));
        hazard      = rs1_pend || rs2_pend || (bus.req_rd_en && rd_pend) || wb_hits_src;
    end

    // Ready is derived from state and hazards only, never from req_valid
    always_comb begin
        req_ready = 1'b0;
        if (!Signal_reset && !hazard) begin
            req_ready = (state_q == IDLE) || ((state_q == VALID) && bus.op_ready);
        end
        accept = bus.req_valid && req_ready;
    end

    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rd_en_d = rd_en_q;

        if (accept) begin
            rs1_d   = bus.req_rs1;
            rs2_d   = bus.req_rs2;
            rd_d    = bus.req_rd;
            rd_en_d = bus.req_rd_en;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = VALID;
            end
            VALID: begin
                if (bus.op_ready) begin
                    state_d = accept ? READ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign bus.req_ready = req_ready;

    // Bank outputs hold while no read is issued, so VALID can drive them straight through
    assign bus.op_valid  = !Signal_reset && (state_q == VALID);
    assign bus.op_a      = bus.rf_out_1;
    assign bus.op_b      = bus.rf_out_2;
    assign bus.op_rd     = rd_q;
    assign bus.op_rd_en  = rd_en_q;

    assign bus.rf_read_1      = rs1_q;
    assign bus.rf_read_2      = rs2_q;
    assign bus.rf_signal_read = !Signal_reset && (state_q == READ);

    assign bus.rf_signal_write     = !Signal_reset && bus.wb_valid;
    assign bus.rf_address_to_write = bus.wb_addr;
    assign bus.rf_data_to_write    = bus.wb_data;

    assign bus.pending_any = !Signal_reset && sb_pending_any;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: bank stub with 1-cycle read latency plus a
// register-value / pending-set reference model driven by directed and random requests.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_access_ctrl_if bus ();

    regfile_access_ctrl u_dut (
        .Clock_in     (clk),
        .Signal_reset (rst),
        .bus          (bus)
    );

    // Bank stub: registered reads, reads return the pre-write value on a same-edge write
    logic [31:0] bank_mem [16] = '{default: '0};
    logic [31:0] bank_o1 = '0;
    logic [31:0] bank_o2 = '0;
    assign bus.rf_out_1 = bank_o1;
    assign bus.rf_out_2 = bank_o2;
    always @(posedge clk) begin
        if (bus.rf_signal_read) begin
            bank_o1 <= bank_mem[bus.rf_read_1];
            bank_o2 <= bank_mem[bus.rf_read_2];
        end
        if (bus.rf_signal_write) bank_mem[bus.rf_address_to_write] <= bus.rf_data_to_write;
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] model_mem [16] = '{default: '0};
    bit          model_pend [16] = '{default: 1'b0};

    function automatic bit model_hazard(logic [3:0] s1, logic [3:0] s2, logic [3:0] d,
                                        logic de, logic wv, logic [3:0] wa);
        return model_pend[s1] || model_pend[s2] || (de && model_pend[d]) ||
               (wv && (wa == s1 || wa == s2));
    endfunction

    function automatic bit model_any();
        bit r = 1'b0;
        for (int i = 0; i < 16; i++) r = r | model_pend[i];
        return r;
    endfunction

    task automatic do_wb(input logic [3:0] a, input logic [31:0] d);
        bus.wb_valid = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        @(posedge clk);
        model_mem[a] = d; model_pend[a] = 1'b0;
        #1 bus.wb_valid = 1'b0;
    endtask

    // Presents one request, waits for acceptance and operands; returns what it observed
    task automatic send_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                            input logic rd_en, input bit consume, output bit accepted,
                            output int lat, output logic [31:0] a, output logic [31:0] b,
                            output logic [3:0] ord, output logic ord_en);
        accepted = 1'b0; lat = 0; a = '0; b = '0; ord = '0; ord_en = 1'b0;
        bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_rd = rd; bus.req_rd_en = rd_en;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready) begin accepted = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!accepted) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (rd_en) model_pend[rd] = 1'b1;
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (bus.op_valid) begin lat = i; break; end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            a = bus.op_a; b = bus.op_b; ord = bus.op_rd; ord_en = bus.op_rd_en;
            $display("txn rs1=%0d rs2=%0d rd=%0d rd_en=%0d lat=%0d a=%h b=%h",
                     rs1, rs2, rd, rd_en, lat, a, b);
            if (consume) bus.op_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req_valid = 1'b1; bus.wb_valid = 1'b1; bus.wb_addr = 4'd1;
        @(posedge clk); #1;
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", bus.op_valid); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.rf_signal_read !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.rf_signal_read); end
        checks++; if (bus.rf_signal_write !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.rf_signal_write); end
        checks++; if (bus.pending_any !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bus.pending_any); end
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL post_reset_op_valid got=%b exp=0", bus.op_valid); end
    endtask

    task automatic test_basic();
        bit acc; int lat; logic [31:0] a, b; logic [3:0] ord; logic orde;
        do_wb(4'd3, 32'hAAAA0003);
        do_wb(4'd5, 32'h55550005);
        send_req(4'd3, 4'd5, 4'd0, 1'b0, 1'b1, acc, lat, a, b, ord, orde);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", acc); end
        checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++; if (a !== 32'hAAAA0003) begin failures++; $display("FAIL basic_op_a got=%h exp=aaaa0003", a); end
        checks++; if (b !== 32'h55550005) begin failures++; $display("FAIL basic_op_b got=%h exp=55550005", b); end
        #1;
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got=%b exp=0", bus.op_valid); end
    endtask

    task automatic test_raw();
        bit acc; int lat; logic [31:0] a, b, ea; logic [3:0] ord; logic orde;
        ea = model_mem[1];
        send_req(4'd1, 4'd2, 4'd7, 1'b1, 1'b1, acc, lat, a, b, ord, orde);
        checks++; if (a !== ea) begin failures++; $display("FAIL raw_first_op_a got=%h exp=%h", a, ea); end
        checks++; if (ord !== 4'd7 || orde !== 1'b1) begin failures++; $display("FAIL raw_op_rd got=%0d/%b exp=7/1", ord, orde); end
        bus.req_rs1 = 4'd7; bus.req_rs2 = 4'd0; bus.req_rd = 4'd0; bus.req_rd_en = 1'b0; bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0 cycle=%0d", bus.req_ready, i); end
            checks++; if (bus.pending_any !== 1'b1) begin failures++; $display("FAIL raw_pending got=%b exp=1", bus.pending_any); end
            @(posedge clk); #1;
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h12345678;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL raw_wb_cycle got=%b exp=0", bus.req_ready); end
        @(posedge clk);
        model_mem[7] = 32'h12345678; model_pend[7] = 1'b0;
        #1 bus.wb_valid = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL raw_release got=%b exp=1", bus.req_ready); end
        send_req(4'd7, 4'd0, 4'd0, 1'b0, 1'b1, acc, lat, a, b, ord, orde);
        checks++; if (a !== 32'h12345678) begin failures++; $display("FAIL raw_op_a got=%h exp=12345678", a); end
        checks++; if (lat != 2) begin failures++; $display("FAIL raw_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_waw();
        bit acc; int lat; logic [31:0] a, b; logic [3:0] ord; logic orde;
        send_req(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, acc, lat, a, b, ord, orde);
        bus.req_rs1 = 4'd0; bus.req_rs2 = 4'd0; bus.req_rd = 4'd9; bus.req_rd_en = 1'b1; bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%b exp=0 cycle=%0d", bus.req_ready, i); end
            @(posedge clk); #1;
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 4'd9; bus.wb_data = 32'h00000999;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL waw_wb_cycle got=%b exp=0", bus.req_ready); end
        @(posedge clk);
        model_mem[9] = 32'h00000999; model_pend[9] = 1'b0;
        #1 bus.wb_valid = 1'b0;
        send_req(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, acc, lat, a, b, ord, orde);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL waw_accept got=%b exp=1", acc); end
        #1;
        checks++; if (bus.pending_any !== 1'b1) begin failures++; $display("FAIL waw_pending got=%b exp=1", bus.pending_any); end
        bus.req_rs1 = 4'd9; bus.req_rd_en = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL waw_repend got=%b exp=0", bus.req_ready); end
        @(posedge clk); #1;
        do_wb(4'd9, 32'h00000909);
        #1;
        checks++; if (bus.pending_any !== 1'b0) begin failures++; $display("FAIL waw_cleared got=%b exp=0", bus.pending_any); end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL waw_ready_again got=%b exp=1", bus.req_ready); end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit acc; int lat; logic [31:0] a, b, ea, eb; logic [3:0] ord; logic orde;
        ea = model_mem[3]; eb = model_mem[5];
        send_req(4'd3, 4'd5, 4'd0, 1'b0, 1'b0, acc, lat, a, b, ord, orde);
        checks++; if (a !== ea) begin failures++; $display("FAIL bp_first_op_a got=%h exp=%h", a, ea); end
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 32'hDEADBEEF;
            #1;
            checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("FAIL bp_op_valid got=%b exp=1 cycle=%0d", bus.op_valid, i); end
            checks++; if (bus.op_a !== ea || bus.op_b !== eb) begin failures++; $display("FAIL bp_operands got=%h/%h exp=%h/%h", bus.op_a, bus.op_b, ea, eb); end
            checks++; if (bus.rf_signal_read !== 1'b0) begin failures++; $display("FAIL bp_read_en got=%b exp=0", bus.rf_signal_read); end
            checks++; if (bus.rf_signal_write !== 1'b1 || bus.rf_address_to_write !== 4'd2 || bus.rf_data_to_write !== 32'hDEADBEEF)
                begin failures++; $display("FAIL bp_write got=%b/%0d/%h exp=1/2/deadbeef", bus.rf_signal_write, bus.rf_address_to_write, bus.rf_data_to_write); end
            checks++; if (bus.pending_any !== 1'b0) begin failures++; $display("FAIL bp_pending got=%b exp=0", bus.pending_any); end
            @(posedge clk); #1;
        end
        model_mem[2] = 32'hDEADBEEF;
        bus.wb_valid = 1'b0; bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        #1;
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", bus.op_valid); end
        send_req(4'd2, 4'd2, 4'd0, 1'b0, 1'b1, acc, lat, a, b, ord, orde);
        checks++; if (a !== 32'hDEADBEEF || b !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_readback got=%h/%h exp=deadbeef", a, b); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic [3:0]  r1, r2;
        localparam int LAST = 16;
        r1 = 4'($urandom_range(0, 15)); r2 = 4'($urandom_range(0, 15));
        bus.req_rs1 = r1; bus.req_rs2 = r2; bus.req_rd = 4'd0; bus.req_rd_en = 1'b0;
        bus.req_valid = 1'b1; bus.op_ready = 1'b1;
        for (int c = 0; c <= LAST; c++) begin
            if (c == LAST) bus.req_valid = 1'b0;
            #1;
            checks++; if (bus.req_ready !== (c % 2 == 0)) begin failures++; $display("FAIL b2b_ready got=%b cycle=%0d", bus.req_ready, c); end
            if (c >= 1) begin
                checks++; if (bus.rf_signal_read !== (c % 2 == 1)) begin failures++; $display("FAIL b2b_read_en got=%b cycle=%0d", bus.rf_signal_read, c); end
                checks++; if (bus.op_valid !== (c % 2 == 0)) begin failures++; $display("FAIL b2b_op_valid got=%b cycle=%0d", bus.op_valid, c); end
            end
            if (bus.op_valid) begin
                checks++;
                if (qa.size() == 0) begin failures++; $display("FAIL b2b_unexpected_op got=%h exp=none", bus.op_a); end
                else begin
                    logic [31:0] ea, eb;
                    ea = qa.pop_front(); eb = qb.pop_front();
                    $display("txn b2b cycle=%0d a=%h b=%h", c, bus.op_a, bus.op_b);
                    if (bus.op_a !== ea || bus.op_b !== eb) begin failures++; $display("FAIL b2b_operands got=%h/%h exp=%h/%h", bus.op_a, bus.op_b, ea, eb); end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                qa.push_back(model_mem[r1]); qb.push_back(model_mem[r2]);
                r1 = 4'($urandom_range(0, 15)); r2 = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            bus.req_rs1 = r1; bus.req_rs2 = r2;
        end
        bus.op_ready = 1'b0;
        checks++; if (qa.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", qa.size()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] s1, s2, d, wa; logic de, wv, exp_rdy; logic [31:0] wd, ea, eb;
            bit acc; int lat;
            s1 = 4'($urandom_range(0, 15)); s2 = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15)); de = 1'($urandom_range(0, 1));
            bus.req_rs1 = s1; bus.req_rs2 = s2; bus.req_rd = d; bus.req_rd_en = de; bus.req_valid = 1'b1;
            acc = 1'b0;
            for (int cyc = 0; cyc < 40 && !acc; cyc++) begin
                wv = 1'b0; wa = 4'($urandom_range(0, 15)); wd = $urandom;
                if (model_any() && $urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < 64; k++) begin
                        if (model_pend[wa]) break;
                        wa = 4'($urandom_range(0, 15));
                    end
                    wv = model_pend[wa];
                end else if ($urandom_range(0, 3) == 0) begin
                    wv = 1'b1;
                end
                bus.wb_valid = wv; bus.wb_addr = wa; bus.wb_data = wd;
                #1;
                exp_rdy = !model_hazard(s1, s2, d, de, wv, wa);
                checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready got=%b exp=%b iter=%0d", bus.req_ready, exp_rdy, n); end
                checks++; if (bus.pending_any !== model_any()) begin failures++; $display("FAIL rnd_pending got=%b exp=%b iter=%0d", bus.pending_any, model_any(), n); end
                @(posedge clk);
                if (wv) begin model_mem[wa] = wd; model_pend[wa] = 1'b0; end
                if (exp_rdy) begin acc = 1'b1; if (de) model_pend[d] = 1'b1; end
                #1 bus.wb_valid = 1'b0;
            end
            bus.req_valid = 1'b0;
            if (!acc) begin
                checks++; failures++; $display("FAIL rnd_accept_timeout got=stalled exp=accepted iter=%0d", n);
                continue;
            end
            ea = model_mem[s1]; eb = model_mem[s2]; lat = 0;
            for (int i = 1; i <= 8; i++) begin
                #1;
                if (bus.op_valid) begin lat = i; break; end
                @(posedge clk); #1;
            end
            checks++; if (lat != 2) begin failures++; $display("FAIL rnd_latency got=%0d exp=2 iter=%0d", lat, n); end
            checks++; if (bus.op_a !== ea || bus.op_b !== eb) begin failures++; $display("FAIL rnd_operands got=%h/%h exp=%h/%h iter=%0d", bus.op_a, bus.op_b, ea, eb, n); end
            checks++; if (bus.op_rd !== d || bus.op_rd_en !== de) begin failures++; $display("FAIL rnd_op_rd got=%0d/%b exp=%0d/%b iter=%0d", bus.op_rd, bus.op_rd_en, d, de, n); end
            $display("txn rnd iter=%0d rs1=%0d rs2=%0d rd=%0d rd_en=%0d a=%h b=%h", n, s1, s2, d, de, bus.op_a, bus.op_b);
            bus.op_ready = 1'b1;
            @(posedge clk); #1;
            bus.op_ready = 1'b0;
        end
        for (int i = 0; i < 16; i++) if (model_pend[i]) do_wb(4'(i), $urandom);
        #1;
        checks++; if (bus.pending_any !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%b exp=0", bus.pending_any); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit acc; int lat; logic [31:0] a, b; logic [3:0] ord; logic orde;
        send_req(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, acc, lat, a, b, ord, orde);
        bus.req_rs1 = 4'd1; bus.req_rs2 = 4'd2; bus.req_rd = 4'd0; bus.req_rd_en = 1'b0; bus.req_valid = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.req_ready); end
        @(posedge clk); #1;
        rst = 1'b1; bus.req_valid = 1'b0;
        #1;
        checks++; if (bus.rf_signal_read !== 1'b0 || bus.op_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.pending_any !== 1'b0)
            begin failures++; $display("FAIL rmid_in_reset got=rd%b/ov%b/rr%b/pa%b exp=0/0/0/0", bus.rf_signal_read, bus.op_valid, bus.req_ready, bus.pending_any); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_pend[i] = 1'b0;
        bus.req_rs1 = 4'd4; bus.req_rs2 = 4'd4;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_after got=%b exp=1", bus.req_ready); end
        checks++; if (bus.pending_any !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b exp=0", bus.pending_any); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.op_valid !== 1'b0 || bus.rf_signal_read !== 1'b0) begin failures++; $display("FAIL rmid_no_op got=ov%b/rd%b exp=0/0 cycle=%0d", bus.op_valid, bus.rf_signal_read, i); end
            @(posedge clk); #2;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0; bus.req_rd_en = 1'b0;
        bus.op_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_raw();
        test_waw();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
